// File: rtl/uart_tx_fifo.sv
// Byte FIFO sitting between a producer and a UART transmitter.
// First-word-fall-through: the head byte is always presented on o_tx_data.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [WIDTH-1:0]         o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake status comes from the stored count alone, so o_ready and
  // o_tx_valid never depend combinationally on i_valid or i_tx_ready.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_push  = i_valid && !w_full;
  assign w_pop   = i_tx_ready && !w_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_valid && w_full)
        r_overflow <= 1'b1;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && w_push)
      r_mem[r_wr_ptr] <= i_data;
  end

  assign o_ready    = !w_full;
  assign o_tx_valid = !w_empty;
  assign o_tx_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
